// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES round sequencing logic.
//   DES_ROUNDS        : rounds in a full DES block
//   round_idx_t       : 4-bit round index
//   sched_state_e     : one-hot state encoding of the round scheduler FSM
//   ENC_SHIFT/DEC_SHIFT : per-round C/D rotate amounts, indexed by round
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef logic [3:0] round_idx_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_ISSUE  = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_FINISH = 4'b1000
  } sched_state_e;

  // Encrypt rotates left starting from the PC1 output, so round 0 already
  // shifts. Decrypt rotates right and round 0 uses C0/D0 unchanged.
  localparam logic [1:0] ENC_SHIFT [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [1:0] DEC_SHIFT [DES_ROUNDS] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_shift_schedule.sv
// -----------------------------------------------------------------------------
// des_shift_schedule
// Pure combinational lookup of the C/D rotate amount for one round.
//   round_idx  in  4  round index 0..15
//   decrypt    in  1  0 = encrypt schedule, 1 = decrypt schedule
//   shift_amt  out 2  rotate amount (0, 1 or 2)
// -----------------------------------------------------------------------------
module des_shift_schedule
  import des_pkg::*;
(
  input  round_idx_t  round_idx,
  input  logic        decrypt,
  output logic [1:0]  shift_amt
);

  always_comb begin
    if (decrypt) shift_amt = DEC_SHIFT[round_idx];
    else         shift_amt = ENC_SHIFT[round_idx];
  end

endmodule

// File: rtl/des_round_scheduler.sv
// -----------------------------------------------------------------------------
// des_round_scheduler
// Steps the shared DES round core through NUM_ROUNDS rounds per job, with a
// start/ready/done handshake per round and a per-round watchdog.
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   ap_start/ap_done/ap_ready/ap_idle   job-level block handshake
//   decrypt               direction, sampled when the job is accepted
//   error                 sticky watchdog abort, cleared on next accept
//   core_start/core_ready/core_done     round core handshake
//   round_idx, shift_amt, shift_dir, first_round   per-round control
//   total_shift           running sum of issued shift amounts
//
// state  | meaning
// IDLE   | waiting for ap_start
// ISSUE  | core_start asserted until core_ready
// WAIT   | round accepted, waiting for core_done, watchdog running
// FINISH | one-cycle ap_done/ap_ready pulse
// -----------------------------------------------------------------------------
module des_round_scheduler
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  input  logic        decrypt,
  output logic        ap_done,
  output logic        ap_ready,
  output logic        ap_idle,
  output logic        error,
  output logic        core_start,
  input  logic        core_ready,
  input  logic        core_done,
  output logic [3:0]  round_idx,
  output logic [1:0]  shift_amt,
  output logic        shift_dir,
  output logic        first_round,
  output logic [4:0]  total_shift
);

  localparam round_idx_t LAST_ROUND = round_idx_t'(NUM_ROUNDS - 1);
  // The watchdog holds the number of completed WAIT cycles, so the limit is
  // reached on the cycle where it still reads TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  sched_state_e     state, state_nxt;
  round_idx_t       round_nxt;
  logic             dir_nxt;
  logic             err_nxt;
  logic [4:0]       tot_nxt;
  logic [CNT_W-1:0] wd, wd_nxt;
  logic             round_done;

  des_shift_schedule u_shift_schedule (
    .round_idx (round_idx),
    .decrypt   (shift_dir),
    .shift_amt (shift_amt)
  );

  assign core_start  = (state == ST_ISSUE);
  assign ap_done     = (state == ST_FINISH);
  assign ap_ready    = (state == ST_FINISH);
  assign ap_idle     = (state == ST_IDLE) && !ap_start;
  assign first_round = (round_idx == '0);

  always_comb begin
    state_nxt  = state;
    round_nxt  = round_idx;
    dir_nxt    = shift_dir;
    err_nxt    = error;
    tot_nxt    = total_shift;
    wd_nxt     = wd;
    round_done = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ap_start) begin
          dir_nxt   = decrypt;
          round_nxt = '0;
          tot_nxt   = '0;
          err_nxt   = 1'b0;
          wd_nxt    = '0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_ready) begin
          tot_nxt = total_shift + {3'b000, shift_amt};
          wd_nxt  = '0;
          // A zero-latency core completes in the accept cycle itself.
          if (core_done) round_done = 1'b1;
          else           state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_nxt = wd + CNT_W'(1);
        if (core_done) begin
          round_done = 1'b1;
        end else if (WD_EN && (wd == WD_LAST)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (round_done) begin
      if (round_idx == LAST_ROUND) begin
        state_nxt = ST_FINISH;
      end else begin
        round_nxt = round_idx + round_idx_t'(1);
        state_nxt = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= ST_IDLE;
      round_idx   <= '0;
      shift_dir   <= 1'b0;
      error       <= 1'b0;
      total_shift <= '0;
      wd          <= '0;
    end else begin
      state       <= state_nxt;
      round_idx   <= round_nxt;
      shift_dir   <= dir_nxt;
      error       <= err_nxt;
      total_shift <= tot_nxt;
      wd          <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_des_round_scheduler.sv
module tb_des_round_scheduler;

  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic       ap_start;
  logic       decrypt;
  logic       ap_done, ap_ready, ap_idle, error;
  logic       core_start, core_ready, core_done;
  logic [3:0] round_idx;
  logic [1:0] shift_amt;
  logic       shift_dir, first_round;
  logic [4:0] total_shift;

  des_round_scheduler #(
    .NUM_ROUNDS     (16),
    .TIMEOUT_CYCLES (10),
    .CNT_W          (8)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .decrypt     (decrypt),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .error       (error),
    .core_start  (core_start),
    .core_ready  (core_ready),
    .core_done   (core_done),
    .round_idx   (round_idx),
    .shift_amt   (shift_amt),
    .shift_dir   (shift_dir),
    .first_round (first_round),
    .total_shift (total_shift)
  );

  always #5 ap_clk = ~ap_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- round core model ----------------
  int  base_dly  = 1;   // cycles from accept to done; 0 = same cycle
  int  sp_round  = -1;  // round using sp_dly instead of base_dly
  int  sp_dly    = 0;
  bit  stall_en  = 0;   // hold ready low 5 cycles in round 3
  bit  spur_done = 0;
  int  stall_cnt = 0;
  int  dly_cnt   = 0;
  int  cur_dly;
  logic stall_now;

  assign cur_dly    = (int'(round_idx) == sp_round) ? sp_dly : base_dly;
  assign stall_now  = stall_en && (round_idx == 4'd3) && (stall_cnt < 5);
  assign core_ready = core_start && !stall_now;
  assign core_done  = (core_start && core_ready && (cur_dly == 0)) ||
                      (dly_cnt == 1) || spur_done;

  always @(posedge ap_clk) begin
    if (ap_rst || ap_done) begin
      dly_cnt   <= 0;
      stall_cnt <= 0;
    end else begin
      if (core_start && core_ready && cur_dly > 0) dly_cnt <= cur_dly;
      else if (dly_cnt > 0)                        dly_cnt <= dly_cnt - 1;
      if (core_start && stall_now) stall_cnt <= stall_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int r;
    int sh;
    bit dir;
  } exp_t;

  exp_t q[$];
  int   hs_cnt     = 0;
  int   stall_seen = 0;

  function automatic int exp_shift(input int r, input bit dec);
    if (r == 0)                        return dec ? 0 : 1;
    if (r == 1 || r == 8 || r == 15)   return 1;
    return 2;
  endfunction

  always @(negedge ap_clk) begin
    if (!ap_rst && core_start && !core_ready) stall_seen++;
    if (!ap_rst && core_start && core_ready) begin
      exp_t e;
      hs_cnt++;
      chk("handshake_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("round_idx", 32'(round_idx), e.r);
        chk("shift_amt", 32'(shift_amt), e.sh);
        chk("shift_dir", 32'(shift_dir), 32'(e.dir));
        chk("first_round", 32'(first_round), 32'(e.r == 0));
      end
    end
  end

  // Runs one job; n_hs is the number of rounds the core is expected to accept.
  task automatic run_job(input bit dec, input int n_hs, output int lat);
    int tot = 0;
    lat = -1;
    for (int r = 0; r < n_hs; r++) begin
      exp_t e;
      e.r = r; e.sh = exp_shift(r, dec); e.dir = dec;
      q.push_back(e);
      tot += e.sh;
    end
    hs_cnt = 0;
    stall_seen = 0;
    @(negedge ap_clk);
    ap_start = 1'b1;
    decrypt  = dec;
    begin
      int c0 = cyc;
      @(negedge ap_clk);
      chk("error_cleared_on_accept", 32'(error), 0);
      if (ap_done) lat = cyc - c0 + 1;
      for (int i = 0; i < 500 && lat < 0; i++) begin
        @(negedge ap_clk);
        if (ap_done) lat = cyc - c0 + 1;
      end
    end
    chk("job_done_seen", 32'(lat >= 0), 1);
    chk("ready_with_done", 32'(ap_ready), 32'(ap_done));
    chk("total_shift", 32'(total_shift), tot % 32);
    chk("handshakes", hs_cnt, n_hs);
    chk("queue_drained", q.size(), 0);
    ap_start = 1'b0;
    decrypt  = 1'b0;
    @(negedge ap_clk);
    chk("done_single_pulse", 32'(ap_done), 0);
    chk("idle_after_job", 32'(ap_idle), 1);
    q.delete();
  endtask

  initial begin
    int lat;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    decrypt  = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", 32'(ap_idle), 1);
    chk("rst_done", 32'(ap_done), 0);
    chk("rst_ready", 32'(ap_ready), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_round_idx", 32'(round_idx), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_total_shift", 32'(total_shift), 0);
    chk("rst_shift_dir", 32'(shift_dir), 0);
    ap_rst = 1'b0;

    // encrypt, 1-cycle core
    run_job(1'b0, 16, lat);
    chk("enc_latency", lat, 34);
    chk("enc_total_28", 32'(total_shift), 28);
    chk("enc_error", 32'(error), 0);

    // decrypt, 1-cycle core
    run_job(1'b1, 16, lat);
    chk("dec_latency", lat, 34);
    chk("dec_total_27", 32'(total_shift), 27);
    chk("dec_dir_latched", 32'(shift_dir), 1);

    // ready held low for 5 cycles in round 3
    stall_en = 1;
    run_job(1'b0, 16, lat);
    chk("stall_cycles", stall_seen, 5);
    chk("stall_latency", lat, 39);
    stall_en = 0;

    // zero-latency core
    base_dly = 0;
    run_job(1'b0, 16, lat);
    chk("zero_lat_latency", lat, 18);
    base_dly = 1;

    // done arrives on the timeout cycle: completion wins
    sp_round = 2; sp_dly = 10;
    run_job(1'b0, 16, lat);
    chk("late_done_latency", lat, 43);
    chk("late_done_no_error", 32'(error), 0);

    // core hangs in round 5
    sp_round = 5; sp_dly = 200;
    run_job(1'b1, 6, lat);
    chk("timeout_latency", lat, 23);
    chk("timeout_error", 32'(error), 1);
    @(negedge ap_clk);
    chk("error_sticky", 32'(error), 1);
    sp_round = -1;

    // spurious done in IDLE is ignored
    spur_done = 1;
    repeat (3) @(negedge ap_clk);
    chk("spur_idle", 32'(ap_idle), 1);
    chk("spur_no_done", 32'(ap_done), 0);
    spur_done = 0;

    // next job clears the error
    run_job(1'b0, 16, lat);
    chk("after_timeout_latency", lat, 34);
    chk("after_timeout_error", 32'(error), 0);

    // reset during WAIT of round 7
    sp_round = 7; sp_dly = 5;
    for (int r = 0; r < 8; r++) begin
      exp_t e;
      e.r = r; e.sh = exp_shift(r, 1'b0); e.dir = 1'b0;
      q.push_back(e);
    end
    @(negedge ap_clk);
    ap_start = 1'b1;
    begin
      bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge ap_clk);
        if (round_idx == 4'd7 && !core_start && !ap_idle) hit = 1;
      end
      chk("reached_round7_wait", 32'(hit), 1);
    end
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    @(negedge ap_clk);
    chk("midrst_idle", 32'(ap_idle), 1);
    chk("midrst_round_idx", 32'(round_idx), 0);
    chk("midrst_core_start", 32'(core_start), 0);
    chk("midrst_done", 32'(ap_done), 0);
    chk("midrst_rounds_issued", q.size(), 0);
    ap_rst = 1'b0;
    sp_round = -1;
    begin
      int done_cnt = 0;
      repeat (10) begin
        @(negedge ap_clk);
        if (ap_done) done_cnt++;
      end
      chk("midrst_no_done_pulse", done_cnt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
